bpm_divider_sched: RTL and testbench

//  Sequences the shared pipelined BPM divider (NUMERATOR / denom, fixed latency). Accepts BPM

---
 rtl/bpm_divider_sched.sv | 146 ++++++++++++++
 tb/tb_bpm_divider_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_divider_sched.sv
// Schedules the shared pipelined BPM divider: clamps tempo requests and holds the denominator
// for the whole pipeline latency. Also sanitises the quotient and queues one latest-wins request.
module bpm_divider_sched #(
    parameter int          DIV_LATENCY = 8,
    parameter logic [39:0] NUMERATOR   = 40'd12000000000,
    parameter logic [33:0] BPM_MIN     = 34'd20,
    parameter logic [33:0] BPM_MAX     = 34'd300
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_bpm_req,
    input  logic [33:0] i_bpm_value,
    output logic [39:0] o_div_numer,
    output logic [39:0] o_div_denom,
    input  logic [39:0] i_div_quotient,
    output logic [33:0] o_trigger_value,
    output logic        o_trigger_valid,
    output logic        o_busy,
    output logic        o_range_err
);

    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [33:0]        denom_reg, denom_next;
    logic               range_err_reg, range_err_next;
    logic               pend_reg, pend_next;
    logic [33:0]        pend_val_reg, pend_val_next;
    logic               pend_err_reg, pend_err_next;
    logic [33:0]        trig_reg, trig_next;
    logic               valid_reg, valid_next;

    logic [33:0]        req_clamped;
    logic               req_clamp_flag;
    logic [33:0]        quot_clean;

    // Zero lands below BPM_MIN, so the divider never sees a zero denominator.
    always_comb begin
        if (i_bpm_value < BPM_MIN)
            req_clamped = BPM_MIN;
        else if (i_bpm_value > BPM_MAX)
            req_clamped = BPM_MAX;
        else
            req_clamped = i_bpm_value;
        req_clamp_flag = (req_clamped != i_bpm_value);
    end

    // Overflowing or all-ones quotients mean a garbage divide result; report 0 instead.
    assign quot_clean = ((i_div_quotient[39:34] != 6'd0) || (i_div_quotient[33:0] == {34{1'b1}}))
                        ? 34'd0 : i_div_quotient[33:0];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        denom_next     = denom_reg;
        range_err_next = range_err_reg;
        pend_next      = pend_reg;
        pend_val_next  = pend_val_reg;
        pend_err_next  = pend_err_reg;
        trig_next      = trig_reg;
        valid_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_bpm_req) begin
                    denom_next     = req_clamped;
                    range_err_next = req_clamp_flag;
                    cnt_next       = CNT_LOAD;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0)
                    state_next = CAPTURE;
                else
                    cnt_next = cnt_reg - 1'b1;
                if (i_bpm_req) begin
                    pend_next     = 1'b1;
                    pend_val_next = req_clamped;
                    pend_err_next = req_clamp_flag;
                end
            end
            CAPTURE: begin
                trig_next  = quot_clean;
                valid_next = 1'b1;
                // A fresh request beats the pending one: latest wins.
                if (i_bpm_req) begin
                    denom_next     = req_clamped;
                    range_err_next = req_clamp_flag;
                    cnt_next       = CNT_LOAD;
                    pend_next      = 1'b0;
                    state_next     = WAIT;
                end else if (pend_reg) begin
                    denom_next     = pend_val_reg;
                    range_err_next = pend_err_reg;
                    cnt_next       = CNT_LOAD;
                    pend_next      = 1'b0;
                    state_next     = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            denom_reg     <= '0;
            range_err_reg <= 1'b0;
            pend_reg      <= 1'b0;
            pend_val_reg  <= '0;
            pend_err_reg  <= 1'b0;
            trig_reg      <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            denom_reg     <= denom_next;
            range_err_reg <= range_err_next;
            pend_reg      <= pend_next;
            pend_val_reg  <= pend_val_next;
            pend_err_reg  <= pend_err_next;
            trig_reg      <= trig_next;
            valid_reg     <= valid_next;
        end
    end

    assign o_div_numer     = NUMERATOR;
    assign o_div_denom     = {6'b0, denom_reg};
    assign o_trigger_value = trig_reg;
    assign o_trigger_valid = valid_reg;
    assign o_busy          = (state_reg != IDLE);
    assign o_range_err     = range_err_reg;

endmodule

// File: tb/tb_bpm_divider_sched.sv
// Directed bench for bpm_divider_sched with a behavioural 8-stage pipelined divider model.
module tb_bpm_divider_sched;

    localparam int          LAT  = 8;
    localparam logic [39:0] NUM  = 40'd12000000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bpm_req = 1'b0;
    logic [33:0] bpm_value = '0;
    logic [39:0] div_numer, div_denom, div_quotient;
    logic [33:0] trigger_value;
    logic        trigger_valid, busy, range_err;
    logic        force_q = 1'b0;
    logic [39:0] pipe [LAT];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bpm_divider_sched #(.DIV_LATENCY(LAT)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_bpm_req      (bpm_req),
        .i_bpm_value    (bpm_value),
        .o_div_numer    (div_numer),
        .o_div_denom    (div_denom),
        .i_div_quotient (div_quotient),
        .o_trigger_value(trigger_value),
        .o_trigger_valid(trigger_valid),
        .o_busy         (busy),
        .o_range_err    (range_err)
    );

    always @(posedge clk) begin
        pipe[0] <= (div_denom == 40'd0) ? 40'd0 : div_numer / div_denom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign div_quotient = force_q ? 40'hFF_FFFF_FFFF : pipe[LAT-1];

    // Issue one request from IDLE and follow it to its strobe (bounded at 30 cycles).
    task automatic run_req(input logic [33:0] v, output int cyc, output logic [33:0] val,
                           output logic [39:0] den, output logic stable);
        logic [33:0] prev;
        bpm_req = 1'b1; bpm_value = v;
        @(posedge clk); #1;
        bpm_req = 1'b0;
        den = div_denom; prev = trigger_value; stable = 1'b1; cyc = 0; val = '0;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (trigger_valid) begin
                val = trigger_value;
                break;
            end
            if (div_denom !== den || trigger_value !== prev || busy !== 1'b1) stable = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({div_denom, trigger_value, trigger_valid, busy, range_err} !== 77'd0) begin
            n_fail++;
            $display("FAIL reset_state: denom=%0d value=%0d valid=%b busy=%b rerr=%b, required all 0",
                     div_denom, trigger_value, trigger_valid, busy, range_err);
        end
        n_checks++;
        if (div_numer !== NUM) begin
            n_fail++;
            $display("FAIL numer_const: got %0d required %0d", div_numer, NUM);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_basic;
        int cyc; logic [33:0] val; logic [39:0] den; logic stable;
        run_req(34'd120, cyc, val, den, stable);
        $display("req 120: denom=%0d cyc=%0d value=%0d rerr=%b", den, cyc, val, range_err);
        n_checks++;
        if (den !== 40'd120) begin n_fail++; $display("FAIL basic_denom: got %0d required 120", den); end
        n_checks++;
        if (cyc !== LAT + 1) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", cyc, LAT + 1); end
        n_checks++;
        if (val !== 34'd100000000) begin n_fail++; $display("FAIL basic_value: got %0d required 100000000", val); end
        n_checks++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL basic_hold: denom/value/busy not stable while computing"); end
        n_checks++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL basic_rerr: got %b required 0", range_err); end
        @(posedge clk); #1;
        n_checks++;
        if (trigger_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_strobe_width: valid=%b busy=%b required 0 0", trigger_valid, busy);
        end
    endtask

    task automatic test_reset_mid_wait;
        int strobes;
        int cyc; logic [33:0] val; logic [39:0] den; logic stable;
        bpm_req = 1'b1; bpm_value = 34'd60;
        @(posedge clk); #1;
        bpm_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("reset mid-wait: denom=%0d value=%0d busy=%b", div_denom, trigger_value, busy);
        n_checks++;
        if ({div_denom, trigger_value, trigger_valid, busy, range_err} !== 77'd0) begin
            n_fail++;
            $display("FAIL midwait_reset: denom=%0d value=%0d valid=%b busy=%b rerr=%b, required all 0",
                     div_denom, trigger_value, trigger_valid, busy, range_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        strobes = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (trigger_valid) strobes++;
        end
        n_checks++;
        if (strobes !== 0) begin n_fail++; $display("FAIL midwait_nostrobe: got %0d strobes required 0", strobes); end
        run_req(34'd120, cyc, val, den, stable);
        $display("post-reset req 120: cyc=%0d value=%0d", cyc, val);
        n_checks++;
        if (cyc !== LAT + 1 || val !== 34'd100000000) begin
            n_fail++; $display("FAIL midwait_accept: cyc=%0d value=%0d required %0d 100000000", cyc, val, LAT + 1);
        end
    endtask

    task automatic test_clamp;
        logic [33:0] reqs [5];
        logic [39:0] exp_den [5];
        logic [33:0] exp_val [5];
        logic        exp_err [5];
        int cyc; logic [33:0] val; logic [39:0] den; logic stable;
        reqs    = '{34'd0, 34'd400, 34'd60, 34'd60, 34'd300};
        exp_den = '{40'd20, 40'd300, 40'd60, 40'd60, 40'd300};
        exp_val = '{34'd600000000, 34'd40000000, 34'd200000000, 34'd200000000, 34'd40000000};
        exp_err = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            run_req(reqs[k], cyc, val, den, stable);
            $display("req %0d: denom=%0d cyc=%0d value=%0d rerr=%b", reqs[k], den, cyc, val, range_err);
            n_checks++;
            if (den !== exp_den[k] || val !== exp_val[k] || range_err !== exp_err[k] ||
                cyc !== LAT + 1 || stable !== 1'b1) begin
                n_fail++;
                $display("FAIL clamp_%0d: denom=%0d value=%0d rerr=%b cyc=%0d stable=%b required %0d %0d %b %0d 1",
                         k, den, val, range_err, cyc, stable, exp_den[k], exp_val[k], exp_err[k], LAT + 1);
            end
        end
    endtask

    // Drives a first request, then extra requests at chosen iterations; collects strobes.
    task automatic queue_run(input logic [33:0] v0, input int c_a, input logic [33:0] v_a,
                             input int c_b, input logic [33:0] v_b, input int c_force,
                             output int n_strobe, output logic [33:0] s0, output logic [33:0] s1,
                             output int t0, output logic busy_gap_ok);
        n_strobe = 0; s0 = '0; s1 = '0; t0 = -1; busy_gap_ok = 1'b1;
        bpm_req = 1'b1; bpm_value = v0;
        @(posedge clk); #1;
        bpm_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bpm_req = 1'b0; force_q = 1'b0;
            if (trigger_valid) begin
                if (n_strobe == 0) begin s0 = trigger_value; t0 = c; end
                else if (n_strobe == 1) s1 = trigger_value;
                n_strobe++;
            end else if (n_strobe == 1 && busy !== 1'b1) busy_gap_ok = 1'b0;
            if (c == c_a) begin bpm_req = 1'b1; bpm_value = v_a; end
            if (c == c_b) begin bpm_req = 1'b1; bpm_value = v_b; end
            if (c == c_force) force_q = 1'b1;
        end
    endtask

    task automatic test_queue;
        int n; logic [33:0] s0, s1; int t0; logic ok;
        queue_run(34'd120, 2, 34'd90, 4, 34'd150, -1, n, s0, s1, t0, ok);
        $display("queue 120,90,150: strobes=%0d first=%0d second=%0d", n, s0, s1);
        n_checks++;
        if (n !== 2) begin n_fail++; $display("FAIL queue_count: got %0d strobes required 2", n); end
        n_checks++;
        if (s0 !== 34'd100000000 || s1 !== 34'd80000000) begin
            n_fail++; $display("FAIL queue_values: got %0d %0d required 100000000 80000000", s0, s1);
        end
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL queue_busy_gap: busy dropped between strobes"); end
    endtask

    task automatic test_back_to_back;
        int n; logic [33:0] s0, s1; int t0; logic ok;
        // 90 goes pending; 60 arrives in the CAPTURE cycle and must replace it.
        queue_run(34'd120, 2, 34'd90, LAT, 34'd60, -1, n, s0, s1, t0, ok);
        $display("capture-cycle req 60: strobes=%0d first=%0d second=%0d", n, s0, s1);
        n_checks++;
        if (n !== 2 || s0 !== 34'd100000000 || s1 !== 34'd200000000) begin
            n_fail++;
            $display("FAIL capture_latest: strobes=%0d values %0d %0d required 2 100000000 200000000", n, s0, s1);
        end
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL capture_busy_gap: busy dropped between strobes"); end
    endtask

    task automatic test_sanitise;
        int n; logic [33:0] s0, s1; int t0; logic ok;
        queue_run(34'd120, -1, 34'd0, -1, 34'd0, LAT, n, s0, s1, t0, ok);
        $display("forced quotient: strobes=%0d at=%0d value=%0d", n, t0, s0);
        n_checks++;
        if (n !== 1 || t0 !== LAT + 1 || s0 !== 34'd0) begin
            n_fail++;
            $display("FAIL sanitise: strobes=%0d at=%0d value=%0d required 1 %0d 0", n, t0, s0, LAT + 1);
        end
        n_checks++;
        if (trigger_value !== 34'd0) begin n_fail++; $display("FAIL sanitise_hold: got %0d required 0", trigger_value); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_reset_mid_wait;
        test_clamp;
        test_queue;
        test_back_to_back;
        test_sanitise;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
